// File: rtl/gpr_wbu.sv
// gpr_wbu: register-file write-back unit.
// Accepts one execute result per transfer. ALU results are written on the
// next cycle. Loads wait for mem_rvalid, are formatted by funct3/addr_lo,
// and are then written.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   in_valid/ready  upstream handshake (ready in IDLE and WRITE)
//   in_rd           destination register index
//   in_result       ALU result
//   in_is_load      load flag
//   in_funct3       load type
//   in_addr_lo      load byte offset
//   mem_rvalid      load data pulse
//   mem_rdata       aligned load word
//   gpr_wen         register-file write enable
//   gpr_waddr       register-file write index
//   gpr_wdata       register-file write data
//   commit          one pulse per retired result (this includes timeouts)
//   err_timeout     sticky: a load was aborted after TIMEOUT wait cycles
//   err_spurious    sticky: mem_rvalid arrived while no load was pending
module gpr_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  commit,
  output logic                  err_timeout,
  output logic                  err_spurious
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("gpr_wbu supports DATA_WIDTH == 32 only");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("gpr_wbu requires TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  // Select a byte or halfword lane from the load word, then sign- or
  // zero-extend it. Words ignore the offset.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = word;
    endcase
  endfunction

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_r, rd_nxt_s;
  logic [2:0]            funct3_r, funct3_nxt_s;
  logic [1:0]            addr_lo_r, addr_lo_nxt_s;
  logic                  wen_nxt_s, commit_nxt_s, ready_nxt_s;
  logic                  err_to_nxt_s, err_sp_nxt_s;
  logic [ADDR_WIDTH-1:0] waddr_nxt_s;
  logic [DATA_WIDTH-1:0] wdata_nxt_s;
  logic                  take_s;

  assign take_s = in_valid & in_ready;

  // Next-state and next-output logic; outputs are registered so every
  // output reflects the state entered at the same edge.
  // The ALU result is captured straight into the write-data register, which
  // is also where it is held while the write is presented.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    rd_nxt_s      = rd_r;
    funct3_nxt_s  = funct3_r;
    addr_lo_nxt_s = addr_lo_r;
    wen_nxt_s     = 1'b0;
    commit_nxt_s  = 1'b0;
    waddr_nxt_s   = gpr_waddr;
    wdata_nxt_s   = gpr_wdata;
    err_to_nxt_s  = err_timeout;
    err_sp_nxt_s  = err_spurious;
    case (state_r)
      IDLE, WRITE: begin
        if (mem_rvalid) begin
          err_sp_nxt_s = 1'b1;
        end else begin
          err_sp_nxt_s = err_spurious;
        end
        if (take_s) begin
          rd_nxt_s      = in_rd;
          funct3_nxt_s  = in_funct3;
          addr_lo_nxt_s = in_addr_lo;
          if (in_is_load) begin
            state_nxt_s = WAIT_MEM;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s  = WRITE;
            wen_nxt_s    = (in_rd != '0);
            commit_nxt_s = 1'b1;
            waddr_nxt_s  = in_rd;
            wdata_nxt_s  = in_result;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt_s  = WRITE;
          wen_nxt_s    = (rd_r != '0);
          commit_nxt_s = 1'b1;
          waddr_nxt_s  = rd_r;
          wdata_nxt_s  = fmt_load(mem_rdata, funct3_r, addr_lo_r);
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          // The counter reaches TIMEOUT as the abort is retired.
          state_nxt_s  = IDLE;
          cnt_nxt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          commit_nxt_s = 1'b1;
          err_to_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    ready_nxt_s = (state_nxt_s != WAIT_MEM);
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      rd_r         <= '0;
      funct3_r     <= 3'd0;
      addr_lo_r    <= 2'd0;
      in_ready     <= 1'b1;
      gpr_wen      <= 1'b0;
      commit       <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      rd_r         <= rd_nxt_s;
      funct3_r     <= funct3_nxt_s;
      addr_lo_r    <= addr_lo_nxt_s;
      in_ready     <= ready_nxt_s;
      gpr_wen      <= wen_nxt_s;
      commit       <= commit_nxt_s;
      gpr_waddr    <= waddr_nxt_s;
      gpr_wdata    <= wdata_nxt_s;
      err_timeout  <= err_to_nxt_s;
      err_spurious <= err_sp_nxt_s;
    end
  end

endmodule

// File: tb/tb_gpr_wbu.sv
// Directed testbench for gpr_wbu (TIMEOUT = 4). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_gpr_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        commit;
  logic        err_timeout;
  logic        err_spurious;

  int passed = 0;
  int total  = 0;

  gpr_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_result(in_result), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .commit(commit), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] exp);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = 5'd7;
    in_funct3  = f3;
    in_addr_lo = lo;
    tick();
    chk({tag, "_wait_ready"}, {31'd0, in_ready}, 32'd0);
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF7F01;
    tick();
    chk({tag, "_wen"},   {31'd0, gpr_wen}, 32'd1);
    chk({tag, "_waddr"}, {27'd0, gpr_waddr}, 32'd7);
    chk({tag, "_wdata"}, gpr_wdata, exp);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
  endtask

  initial begin
    // Reset with in_valid and mem_rvalid active: both must be ignored.
    rst        = 1'b0;
    in_valid   = 1'b1;
    in_rd      = 5'd3;
    in_result  = 32'h55;
    in_is_load = 1'b0;
    in_funct3  = 3'd0;
    in_addr_lo = 2'd0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    chk("rst_wen",      {31'd0, gpr_wen}, 32'd0);
    chk("rst_commit",   {31'd0, commit}, 32'd0);
    chk("rst_waddr",    {27'd0, gpr_waddr}, 32'd0);
    chk("rst_wdata",    gpr_wdata, 32'd0);
    chk("rst_err_to",   {31'd0, err_timeout}, 32'd0);
    chk("rst_err_sp",   {31'd0, err_spurious}, 32'd0);
    chk("rst_ready",    {31'd0, in_ready}, 32'd1);
    rst        = 1'b1;
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    chk("idle_wen", {31'd0, gpr_wen}, 32'd0);

    // ALU result, one-cycle latency.
    in_valid  = 1'b1;
    in_rd     = 5'd5;
    in_result = 32'hDEADBEEF;
    tick();
    chk("alu_wen",    {31'd0, gpr_wen}, 32'd1);
    chk("alu_waddr",  {27'd0, gpr_waddr}, 32'd5);
    chk("alu_wdata",  gpr_wdata, 32'hDEADBEEF);
    chk("alu_commit", {31'd0, commit}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("alu_after_wen",    {31'd0, gpr_wen}, 32'd0);
    chk("alu_after_commit", {31'd0, commit}, 32'd0);
    chk("alu_hold_waddr",   {27'd0, gpr_waddr}, 32'd5);
    chk("alu_hold_wdata",   gpr_wdata, 32'hDEADBEEF);

    // Load formats on 0x80FF7F01.
    do_load("lb3",  3'b000, 2'd3, 32'hFFFFFF80);
    do_load("lbu1", 3'b100, 2'd1, 32'h0000007F);
    do_load("lh2",  3'b001, 2'd2, 32'hFFFF80FF);
    do_load("lh3",  3'b001, 2'd3, 32'hFFFF80FF);
    do_load("lhu0", 3'b101, 2'd0, 32'h00007F01);
    do_load("lw",   3'b010, 2'd3, 32'h80FF7F01);
    do_load("f3_7", 3'b111, 2'd1, 32'h80FF7F01);

    // Write to x0: commit without write enable.
    in_valid  = 1'b1;
    in_rd     = 5'd0;
    in_result = 32'h1234;
    tick();
    chk("x0_commit", {31'd0, commit}, 32'd1);
    chk("x0_wen",    {31'd0, gpr_wen}, 32'd0);
    in_valid = 1'b0;
    tick();

    // Load timeout: 4 cycles not ready, then abort pulse.
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = 5'd9;
    tick();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_ready_low", {31'd0, in_ready}, 32'd0);
      chk("to_no_commit", {31'd0, commit}, 32'd0);
      tick();
    end
    chk("to_commit", {31'd0, commit}, 32'd1);
    chk("to_wen",    {31'd0, gpr_wen}, 32'd0);
    chk("to_err",    {31'd0, err_timeout}, 32'd1);
    chk("to_ready",  {31'd0, in_ready}, 32'd1);
    tick();
    chk("to_commit_end", {31'd0, commit}, 32'd0);
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    chk("to_no_sp",      {31'd0, err_spurious}, 32'd0);

    // Back-to-back ALU results.
    in_valid  = 1'b1;
    in_rd     = 5'd1;
    in_result = 32'h11;
    tick();
    chk("b2b1_wen",   {31'd0, gpr_wen}, 32'd1);
    chk("b2b1_waddr", {27'd0, gpr_waddr}, 32'd1);
    chk("b2b1_wdata", gpr_wdata, 32'h11);
    in_rd     = 5'd2;
    in_result = 32'h22;
    tick();
    chk("b2b2_wen",   {31'd0, gpr_wen}, 32'd1);
    chk("b2b2_waddr", {27'd0, gpr_waddr}, 32'd2);
    chk("b2b2_wdata", gpr_wdata, 32'h22);
    in_rd     = 5'd3;
    in_result = 32'h33;
    tick();
    chk("b2b3_wen",   {31'd0, gpr_wen}, 32'd1);
    chk("b2b3_waddr", {27'd0, gpr_waddr}, 32'd3);
    chk("b2b3_wdata", gpr_wdata, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("b2b_end_wen", {31'd0, gpr_wen}, 32'd0);

    // Spurious mem_rvalid in IDLE.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("sp_wen",    {31'd0, gpr_wen}, 32'd0);
    chk("sp_commit", {31'd0, commit}, 32'd0);
    chk("sp_err",    {31'd0, err_spurious}, 32'd1);
    chk("sp_wdata",  gpr_wdata, 32'h33);

    // Reset during WAIT_MEM, then late mem_rvalid.
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = 5'd4;
    in_funct3  = 3'b010;
    tick();
    chk("rw_wait_ready", {31'd0, in_ready}, 32'd0);
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    rst        = 1'b0;
    tick();
    chk("rw_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rw_rst_sp",    {31'd0, err_spurious}, 32'd0);
    chk("rw_rst_to",    {31'd0, err_timeout}, 32'd0);
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_wen",    {31'd0, gpr_wen}, 32'd0);
    chk("rw_commit", {31'd0, commit}, 32'd0);
    chk("rw_sp",     {31'd0, err_spurious}, 32'd1);
    chk("rw_wdata",  gpr_wdata, 32'd0);
    tick();
    chk("rw_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("rw_idle_wen",   {31'd0, gpr_wen}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
